// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of an 8x8 bitcell memory: grants one request at a
// time, drives a one-cycle read/write strobe, holds address/data and captures read data.
module mem_port_arbiter #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_adr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_adr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, ACCESS, RESP} state_t;

   state_t            state_reg, state_next;
   logic              grant_reg, grant_next;
   logic              last_grant_reg, last_grant_next;
   logic              op_we_reg, op_we_next;
   logic [ADDR_W-1:0] adr_reg, adr_next;
   logic [DATA_W-1:0] din_reg, din_next;
   logic [DATA_W-1:0] rdata_reg, rdata_next;

   logic [1:0]        req_vec, we_vec, ack_vec;
   logic [ADDR_W-1:0] adr_vec   [2];
   logic [DATA_W-1:0] wdata_vec [2];
   logic              sel, any_req;

   assign req_vec      = {p1_req, p0_req};
   assign we_vec       = {p1_we, p0_we};
   assign adr_vec[0]   = p0_adr;
   assign adr_vec[1]   = p1_adr;
   assign wdata_vec[0] = p0_wdata;
   assign wdata_vec[1] = p1_wdata;

   // Ack is suppressed while reset is asserted so an aborted access never completes.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == RESP) && (grant_reg == 1'(gi)) && !reset;
   end

   always_comb begin
      any_req = |req_vec;
      if (&req_vec) sel = RR_EN ? ~last_grant_reg : 1'b0;
      else          sel = req_vec[1];
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      op_we_next      = op_we_reg;
      adr_next        = adr_reg;
      din_next        = din_reg;
      rdata_next      = rdata_reg;
      case (state_reg)
         IDLE:    state_next = any_req ? ISSUE : IDLE;
         ISSUE:   state_next = ACCESS;
         ACCESS: begin
            if (!op_we_reg) rdata_next = mem_dout;
            state_next = RESP;
         end
         RESP:    state_next = any_req ? ISSUE : IDLE;
         default: state_next = IDLE;
      endcase
      // Selection happens from IDLE and directly out of RESP for back-to-back service.
      if (any_req && (state_reg == IDLE || state_reg == RESP)) begin
         grant_next      = sel;
         last_grant_next = sel;
         op_we_next      = we_vec[sel];
         adr_next        = adr_vec[sel];
         din_next        = wdata_vec[sel];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         op_we_reg      <= 1'b0;
         adr_reg        <= '0;
         din_reg        <= '0;
         rdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         op_we_reg      <= op_we_next;
         adr_reg        <= adr_next;
         din_reg        <= din_next;
         rdata_reg      <= rdata_next;
      end
   end

   assign p0_ack    = ack_vec[0];
   assign p1_ack    = ack_vec[1];
   assign rdata     = rdata_reg;
   assign busy      = (state_reg != IDLE);
   assign mem_read  = (state_reg == ISSUE) && !op_we_reg;
   assign mem_write = (state_reg == ISSUE) && op_we_reg;
   assign mem_adr   = adr_reg;
   assign mem_din   = din_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller that shares one 8-word x 8-bit bitcell memory system between port 0 and port 1.
- The memory system has its own read/write FSM and address decoder.
- This block arbitrates requests, sequences the read/write strobes to meet the memory FSM's one-cycle registered-enable timing, holds address and data stable, and captures read data.
- It sits between client logic and the memory system, and owns all of the memory's read, write, adr and inputs pins.

Parameters:
- ADDR_W, 3: address width; fixed by the 8-word memory.
- DATA_W, 8: word width; fixed by the 8-bit memory.
- RR_EN, 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read; stable while p0_req is high.
- p0_adr  in  ADDR_W  port 0 word address; stable while p0_req is high.
- p0_wdata  in  DATA_W  port 0 write data; stable while p0_req is high.
- p0_ack  out  1  one-cycle completion pulse for port 0.
- p1_req, p1_we, p1_adr, p1_wdata, p1_ack: same as port 0, for port 1.
- rdata  out  DATA_W  captured read data; valid in the ack cycle of a read, held until the next read completes.
- busy  out  1  high in any state other than IDLE.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_adr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory output (combinational from the bitcell array).

Behaviour:
- Reset values: state = IDLE; all outputs 0; last_grant = 1, so port 0 wins the first tie.
- State IDLE:
  - If any req is high, select a winner, latch its we/adr/wdata into mem_adr/mem_din/op, then go to ISSUE.
  - Otherwise stay in IDLE.
- Winner selection:
  - A single requester wins.
  - With both requesting: RR_EN=1 grants the port not equal to last_grant; RR_EN=0 grants port 0.
  - last_grant updates on every selection.
- State ISSUE (1 cycle):
  - mem_read = !op_we, mem_write = op_we. Exactly one strobe is high; both strobes high is never driven.
  - mem_adr and mem_din are held.
  - Next state is ACCESS.
- State ACCESS (1 cycle):
  - Both strobes are 0; mem_adr and mem_din are held. The memory FSM's registered enable/rw are active this cycle.
  - For a read, mem_dout is sampled into rdata at the end of this cycle.
  - Next state is RESP.
- State RESP (1 cycle):
  - The granted port's ack = 1; rdata is valid for a read.
  - If any req is high (excluding the port just acked, which must drop req this cycle), arbitrate and go directly to ISSUE. Otherwise go to IDLE.
- Latency: req sampled high in IDLE -> ack exactly 3 cycles later. Back-to-back throughput is one access per 3 cycles.
- A write never modifies rdata. Reading a never-written word returns the memory's power-up value; the bench does not check it.
- A port that keeps req high after its ack is treated as a new request. Under RR_EN=1 it is served only after the other port's pending request.
- Ack pulses are mutually exclusive and never exceed one cycle.
- Reset mid-operation:
  - Reset asserted in ISSUE, ACCESS or RESP aborts the access; no ack is issued, and the next state is IDLE with the reset values above.
  - A write whose ISSUE cycle coincides with reset may still land in the memory at address 0 with 0x00, because the memory FSM is not reset by this block. The content of word 0 is undefined after such a reset.
  - Read aborts leave memory unaffected.
- Request changes while not granted are legal. Only the latched copy is used after selection.

Test Plan:
- Single write/read: p0 writes adr 3 = 0x53, then reads adr 3 -> p0_ack 3 cycles after each req; mem_write high only in the ISSUE cycle; rdata = 0x53 in the read ack cycle.
- Simultaneous requests, RR_EN=1, after reset: p0 writes adr 1 = 0x69 and p1 writes adr 2 = 0x6E in the same cycle -> p0_ack first, p1_ack 3 cycles later; subsequent reads return 0x69 and 0x6E.
- Fairness: both ports hold reads continuously for 6 accesses -> acks alternate p0, p1, p0, p1, p0, p1; busy stays high throughout.
- RR_EN=0: both ports request continuously -> p0 acked every 3 cycles; p1 is never acked until p0_req drops.
- Fill and readback: write "Sindre" (0x53, 0x69, 0x6E, 0x64, 0x72, 0x65) to adr 0-5 alternating ports, then read all 6 -> each read returns the exact byte; no strobe overlap.
- Reset in ACCESS of a p1 read -> no p1_ack; all outputs 0 the next cycle; a following p0 read of adr 5 returns 0x65.
